// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional write-to-read bypass,
// a per-register busy scoreboard and a sequential bulk-clear engine.
// Decode reads operands and marks producers pending; writeback commits
// results and retires the pending marks.
module regfile_mp #(
   parameter int XLEN     = 32,
   parameter int NREG     = 32,
   parameter int NRD      = 2,
   parameter int NWR      = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NWR-1:0]            i_wr_en,
   input  logic [NWR*$clog2(NREG)-1:0] i_wr_idx,
   input  logic [NWR*XLEN-1:0]       i_wr_data,
   input  logic [NRD*$clog2(NREG)-1:0] i_rd_idx,
   output logic [NRD*XLEN-1:0]       o_rd_data,
   output logic [NRD-1:0]            o_rd_busy,
   input  logic                      i_sb_set_en,
   input  logic [$clog2(NREG)-1:0]   i_sb_set_idx,
   input  logic                      i_clr_req,
   output logic                      o_clr_busy
);

   localparam int AW = $clog2(NREG);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_CLEAR = 1'b1
   } state_t;

   state_t          r_state;
   logic [AW-1:0]   r_cnt;
   logic            r_clr_busy;
   logic [XLEN-1:0] r_regs [NREG];
   logic [NREG-1:0] r_busy;

   // True when idx addresses the hardwired-zero register.
   function automatic logic f_is_zero(input logic [AW-1:0] idx);
      return (ZERO_REG != 0) && (idx == '0);
   endfunction

   // Read value for one index: stored value, optionally overridden by a
   // same-cycle write (highest port wins), forced to zero for register 0.
   function automatic logic [XLEN-1:0] f_read(input logic [AW-1:0] idx);
      logic [XLEN-1:0] v_val;
      v_val = r_regs[idx];
      if ((BYPASS != 0) && (r_state == S_IDLE)) begin
         for (int p = 0; p < NWR; p++) begin
            if (i_wr_en[p] && (i_wr_idx[p*AW +: AW] == idx))
               v_val = i_wr_data[p*XLEN +: XLEN];
         end
      end
      if (f_is_zero(idx))
         v_val = '0;
      return v_val;
   endfunction

   // Storage, scoreboard and clear FSM share one clocked process so that the
   // clear engine has sole ownership of the array while it runs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the whole array is reset here, not just the control state,
         // because an async reset must make every read return zero at once,
         // including in the middle of a bulk clear.
         for (int r = 0; r < NREG; r++)
            r_regs[r] <= '0;
         r_busy     <= '0;
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_clr_busy <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               // NOTE: non-blocking assignments issued in ascending port
               // order; the last one scheduled for an index takes effect,
               // so the highest-numbered port wins a write collision.
               for (int p = 0; p < NWR; p++) begin
                  if (i_wr_en[p] && !f_is_zero(i_wr_idx[p*AW +: AW])) begin
                     r_regs[i_wr_idx[p*AW +: AW]] <= i_wr_data[p*XLEN +: XLEN];
                     r_busy[i_wr_idx[p*AW +: AW]] <= 1'b0;
                  end
               end
               // Scheduled after the write clears so a same-cycle set wins.
               if (i_sb_set_en && !f_is_zero(i_sb_set_idx))
                  r_busy[i_sb_set_idx] <= 1'b1;
               if (i_clr_req) begin
                  r_state    <= S_CLEAR;
                  r_cnt      <= '0;
                  r_clr_busy <= 1'b1;
               end
            end
            S_CLEAR: begin
               r_regs[r_cnt] <= '0;
               r_busy[r_cnt] <= 1'b0;
               r_cnt         <= r_cnt + 1'b1;
               if (r_cnt == AW'(NREG - 1)) begin
                  r_state    <= S_IDLE;
                  r_clr_busy <= 1'b0;
               end
            end
            default: begin
               r_state    <= S_IDLE;
               r_clr_busy <= 1'b0;
            end
         endcase
      end
   end

   // Combinational read ports and scoreboard lookups.
   always_comb begin
      // NOTE: outputs get a default before the loop so no path leaves them
      // unassigned, which would otherwise infer latches.
      o_rd_data = '0;
      o_rd_busy = '0;
      for (int q = 0; q < NRD; q++) begin
         o_rd_data[q*XLEN +: XLEN] = f_read(i_rd_idx[q*AW +: AW]);
         o_rd_busy[q]              = r_busy[i_rd_idx[q*AW +: AW]];
      end
   end

   assign o_clr_busy = r_clr_busy;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp: default configuration,
// a non-bypassed copy sharing its inputs, and a wide 16x64 / 4R3W variant
// with register 0 writable.
module tb_regfile_mp;

   logic clk = 1'b0;
   logic rst;

   // Default configuration (XLEN=32, NREG=32, NRD=2, NWR=2)
   logic [1:0]  wr_en;
   logic [9:0]  wr_idx;
   logic [63:0] wr_data;
   logic [9:0]  rd_idx;
   logic [63:0] rd_data, rd_data_nb;
   logic [1:0]  rd_busy, rd_busy_nb;
   logic        sb_set_en;
   logic [4:0]  sb_set_idx;
   logic        clr_req;
   logic        clr_busy, clr_busy_nb;

   // Wide configuration (XLEN=64, NREG=16, NRD=4, NWR=3, ZERO_REG=0)
   logic [2:0]   w_wr_en;
   logic [11:0]  w_wr_idx;
   logic [191:0] w_wr_data;
   logic [15:0]  w_rd_idx;
   logic [255:0] w_rd_data;
   logic [3:0]   w_rd_busy;
   logic         w_sb_set_en;
   logic [3:0]   w_sb_set_idx;
   logic         w_clr_req;
   logic         w_clr_busy;

   int n_checks = 0;
   int n_errors = 0;
   int n_cyc;

   always #5 clk = ~clk;

   regfile_mp u_dut (
      .clk(clk), .rst(rst),
      .i_wr_en(wr_en), .i_wr_idx(wr_idx), .i_wr_data(wr_data),
      .i_rd_idx(rd_idx), .o_rd_data(rd_data), .o_rd_busy(rd_busy),
      .i_sb_set_en(sb_set_en), .i_sb_set_idx(sb_set_idx),
      .i_clr_req(clr_req), .o_clr_busy(clr_busy)
   );

   regfile_mp #(.BYPASS(0)) u_nb (
      .clk(clk), .rst(rst),
      .i_wr_en(wr_en), .i_wr_idx(wr_idx), .i_wr_data(wr_data),
      .i_rd_idx(rd_idx), .o_rd_data(rd_data_nb), .o_rd_busy(rd_busy_nb),
      .i_sb_set_en(sb_set_en), .i_sb_set_idx(sb_set_idx),
      .i_clr_req(clr_req), .o_clr_busy(clr_busy_nb)
   );

   regfile_mp #(.XLEN(64), .NREG(16), .NRD(4), .NWR(3), .ZERO_REG(0)) u_wide (
      .clk(clk), .rst(rst),
      .i_wr_en(w_wr_en), .i_wr_idx(w_wr_idx), .i_wr_data(w_wr_data),
      .i_rd_idx(w_rd_idx), .o_rd_data(w_rd_data), .o_rd_busy(w_rd_busy),
      .i_sb_set_en(w_sb_set_en), .i_sb_set_idx(w_sb_set_idx),
      .i_clr_req(w_clr_req), .o_clr_busy(w_clr_busy)
   );

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en      = '0;
      wr_idx     = '0;
      wr_data    = '0;
      sb_set_en  = 1'b0;
      sb_set_idx = '0;
      clr_req    = 1'b0;
   endtask

   task automatic widle();
      w_wr_en      = '0;
      w_wr_idx     = '0;
      w_wr_data    = '0;
      w_sb_set_en  = 1'b0;
      w_sb_set_idx = '0;
      w_clr_req    = 1'b0;
   endtask

   task automatic wr(input int p, input logic [4:0] idx, input logic [31:0] data);
      wr_en[p]            = 1'b1;
      wr_idx[p*5 +: 5]    = idx;
      wr_data[p*32 +: 32] = data;
   endtask

   task automatic rd(input int p, input logic [4:0] idx);
      rd_idx[p*5 +: 5] = idx;
   endtask

   task automatic wwr(input int p, input logic [3:0] idx, input logic [63:0] data);
      w_wr_en[p]            = 1'b1;
      w_wr_idx[p*4 +: 4]    = idx;
      w_wr_data[p*64 +: 64] = data;
   endtask

   task automatic wrd(input int p, input logic [3:0] idx);
      w_rd_idx[p*4 +: 4] = idx;
   endtask

   initial begin
      // Reset state
      rst = 1'b1;
      idle();
      widle();
      rd_idx   = '0;
      w_rd_idx = '0;
      #2;
      check("rst_rd_data", rd_data, 64'h0);
      check("rst_rd_busy", rd_busy, 2'b00);
      check("rst_clr_busy", clr_busy, 1'b0);
      check("rst_wide_rd_data", w_rd_data, 256'h0);
      rst = 1'b0;
      tick();

      // Basic write, bypass and zero register
      wr(0, 5'd5, 32'hDEADBEEF);
      wr(1, 5'd0, 32'h0000_1234);
      rd(0, 5'd5);
      rd(1, 5'd0);
      #1;
      check("byp_rd5", rd_data[31:0], 32'hDEADBEEF);
      check("nb_rd5_old", rd_data_nb[31:0], 32'h0);
      check("byp_rd0_zero", rd_data[63:32], 32'h0);
      tick();
      idle();
      #1;
      check("rd5", rd_data[31:0], 32'hDEADBEEF);
      check("nb_rd5", rd_data_nb[31:0], 32'hDEADBEEF);
      check("rd0_zero", rd_data[63:32], 32'h0);

      // Write collision on idx7: port 1 wins
      wr(0, 5'd7, 32'h99);
      tick();
      idle();
      wr(0, 5'd7, 32'h11);
      wr(1, 5'd7, 32'h22);
      rd(0, 5'd7);
      #1;
      check("byp_collide", rd_data[31:0], 32'h22);
      check("nb_collide_old", rd_data_nb[31:0], 32'h99);
      tick();
      idle();
      #1;
      check("collide_stored", rd_data[31:0], 32'h22);
      check("nb_collide_stored", rd_data_nb[31:0], 32'h22);

      // Scoreboard
      sb_set_en  = 1'b1;
      sb_set_idx = 5'd3;
      rd(1, 5'd3);
      #1;
      check("sb_no_fwd", rd_busy[1], 1'b0);
      tick();
      idle();
      #1;
      check("sb_set", rd_busy[1], 1'b1);
      wr(0, 5'd3, 32'h33);
      #1;
      check("sb_clr_no_fwd", rd_busy[1], 1'b1);
      tick();
      idle();
      #1;
      check("sb_cleared", rd_busy[1], 1'b0);
      wr(0, 5'd3, 32'h34);
      sb_set_en  = 1'b1;
      sb_set_idx = 5'd3;
      tick();
      idle();
      #1;
      check("sb_set_wins", rd_busy[1], 1'b1);
      sb_set_en  = 1'b1;
      sb_set_idx = 5'd0;
      rd(1, 5'd0);
      tick();
      idle();
      #1;
      check("sb_zero_never", rd_busy[1], 1'b0);

      // Fill every register and mark 16..31 busy
      for (int i = 0; i < 16; i++) begin
         wr(0, 5'(2*i), 32'h100 + 32'(2*i));
         wr(1, 5'(2*i+1), 32'h101 + 32'(2*i));
         sb_set_en  = 1'b1;
         sb_set_idx = 5'(i + 16);
         tick();
      end
      idle();
      rd(0, 5'd31);
      rd(1, 5'd0);
      #1;
      check("fill_rd31", rd_data[31:0], 32'h11F);
      check("fill_busy31", rd_busy[0], 1'b1);
      check("fill_rd0_zero", rd_data[63:32], 32'h0);

      // Bulk clear with a same-cycle write that must commit first
      wr(1, 5'd9, 32'hABCD);
      clr_req = 1'b1;
      tick();
      idle();
      wr(0, 5'd1, 32'h5555);
      wr(1, 5'd31, 32'h6666);
      sb_set_en  = 1'b1;
      sb_set_idx = 5'd2;
      clr_req    = 1'b1;
      rd(0, 5'd31);
      rd(1, 5'd9);
      #1;
      check("clr_first_busy", clr_busy, 1'b1);
      check("clr_no_bypass", rd_data[31:0], 32'h11F);
      check("clr_write_committed", rd_data[63:32], 32'hABCD);
      n_cyc = 0;
      while (clr_busy === 1'b1 && n_cyc < 100) begin
         n_cyc++;
         tick();
      end
      check("clr_length", 32'(n_cyc), 32'd32);
      idle();
      wr(0, 5'd4, 32'h44);
      tick();
      idle();
      for (int i = 0; i < 32; i++) begin
         rd(0, 5'(i));
         rd(1, 5'(i));
         #1;
         check($sformatf("post_clr_rd%0d", i), rd_data[31:0], (i == 4) ? 32'h44 : 32'h0);
         check($sformatf("post_clr_busy%0d", i), rd_busy, 2'b00);
         tick();
      end

      // Reset in the middle of a clear
      wr(0, 5'd31, 32'h31);
      sb_set_en  = 1'b1;
      sb_set_idx = 5'd12;
      tick();
      idle();
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      repeat (9) tick();
      rd(0, 5'd31);
      rd(1, 5'd12);
      #1;
      check("midclr_busy", clr_busy, 1'b1);
      check("midclr_rd31", rd_data[31:0], 32'h31);
      check("midclr_sb12", rd_busy[1], 1'b1);
      rst = 1'b1;
      #1;
      check("rst_midclr_clr_busy", clr_busy, 1'b0);
      check("rst_midclr_rd31", rd_data[31:0], 32'h0);
      check("rst_midclr_sb12", rd_busy[1], 1'b0);
      rst = 1'b0;
      tick();
      wr(0, 5'd20, 32'h2020);
      tick();
      idle();
      rd(0, 5'd20);
      #1;
      check("post_rst_write", rd_data[31:0], 32'h2020);
      check("post_rst_clr_busy", clr_busy, 1'b0);

      // Wide variant: register 0 writable, 64-bit data on all ports
      wwr(2, 4'd0, 64'h0123_4567_89AB_CDEF);
      wwr(0, 4'd15, 64'hFEDC_BA98_7654_3210);
      wwr(1, 4'd8, 64'h8000_0000_0000_0001);
      wrd(0, 4'd0);
      wrd(1, 4'd15);
      wrd(2, 4'd8);
      wrd(3, 4'd5);
      #1;
      check("w_byp_idx0", w_rd_data[63:0], 64'h0123_4567_89AB_CDEF);
      tick();
      widle();
      #1;
      check("w_rd_idx0", w_rd_data[63:0], 64'h0123_4567_89AB_CDEF);
      check("w_rd_idx15", w_rd_data[127:64], 64'hFEDC_BA98_7654_3210);
      check("w_rd_idx8", w_rd_data[191:128], 64'h8000_0000_0000_0001);
      check("w_rd_idx5", w_rd_data[255:192], 64'h0);
      wwr(0, 4'd5, 64'hAAAA_AAAA_AAAA_AAAA);
      wwr(1, 4'd5, 64'hBBBB_BBBB_BBBB_BBBB);
      wwr(2, 4'd5, 64'hCCCC_CCCC_CCCC_CCCC);
      w_sb_set_en  = 1'b1;
      w_sb_set_idx = 4'd0;
      #1;
      check("w_byp_collide", w_rd_data[255:192], 64'hCCCC_CCCC_CCCC_CCCC);
      tick();
      widle();
      #1;
      check("w_collide_stored", w_rd_data[255:192], 64'hCCCC_CCCC_CCCC_CCCC);
      check("w_busy_idx0", w_rd_busy, 4'b0001);
      check("w_clr_busy", w_clr_busy, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
